// File: rtl/rsv_prf_param.sv
// Parametrised physical register file for the issue stage.
// Holds NUM_RD combinational read ports and NUM_WR write ports. Each entry has a
// ready bit that is cleared by rename allocations and set by writebacks. Same-cycle
// writes can optionally be forwarded to reads. After reset, a sweep writes zero to
// every entry, so no entry is ever read back as X.
module rsv_prf_param #(
    parameter int PRF_NUMS  = 128,
    parameter int DATA_W    = 64,
    parameter int NUM_RD    = 8,
    parameter int NUM_WR    = 4,
    parameter int NUM_ALLOC = 4,
    parameter int BYPASS    = 1,
    localparam int CODE_W   = $clog2(PRF_NUMS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ALLOC-1:0]          i_alloc_vld,
    input  logic [NUM_ALLOC*CODE_W-1:0]   i_alloc_code,
    input  logic [NUM_RD*CODE_W-1:0]      i_rd_code,
    output logic [NUM_RD*DATA_W-1:0]      o_rd_data,
    input  logic [NUM_WR-1:0]             i_wr_en,
    input  logic [NUM_WR*CODE_W-1:0]      i_wr_code,
    input  logic [NUM_WR*DATA_W-1:0]      i_wr_data,
    output logic [PRF_NUMS-1:0]           o_ready,
    output logic                          o_init_done
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Wide enough to hold the sweep counter after its final increment.
    localparam int CNT_W = $clog2(PRF_NUMS + NUM_WR) + 1;

    logic [0:0]                 state_reg;
    logic [CNT_W-1:0]           cnt_reg;
    logic [CNT_W:0]             cnt_plus;
    logic                       init_last;
    logic                       run;
    logic [PRF_NUMS-1:0]        ready_reg;
    logic [PRF_NUMS-1:0]        ready_next;
    logic                       init_done_reg;

    logic [DATA_W-1:0]          mem [PRF_NUMS];

    // Per-entry decode results.
    logic [PRF_NUMS-1:0]                set_vec;
    logic [PRF_NUMS-1:0]                clr_vec;
    logic [PRF_NUMS-1:0]                wr_we;
    logic [PRF_NUMS-1:0]                sweep_we;
    logic [PRF_NUMS-1:0][DATA_W-1:0]    ent_wd;

    assign run       = (state_reg == ST_RUN);
    assign cnt_plus  = {1'b0, cnt_reg} + (CNT_W+1)'(NUM_WR);
    assign init_last = (cnt_plus >= (CNT_W+1)'(PRF_NUMS));

    // Entry-side decode: which write port (if any) targets this entry, whether the
    // sweep covers it this cycle, and whether an allocation clears its ready bit.
    for (genvar gi = 0; gi < PRF_NUMS; gi++) begin : g_ent
        logic              hit;
        logic [DATA_W-1:0] wd;
        logic              alloc_hit;

        // Ascending scan so the highest-numbered matching port has the last word.
        always_comb begin
            hit = 1'b0;
            wd  = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (i_wr_en[p] && (i_wr_code[p*CODE_W +: CODE_W] == CODE_W'(gi))) begin
                    hit = 1'b1;
                    wd  = i_wr_data[p*DATA_W +: DATA_W];
                end
            end
        end

        // Any valid allocation naming this entry clears its ready bit.
        always_comb begin
            alloc_hit = 1'b0;
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (i_alloc_vld[a] && (i_alloc_code[a*CODE_W +: CODE_W] == CODE_W'(gi))) begin
                    alloc_hit = 1'b1;
                end
            end
        end

        assign set_vec[gi]  = hit;
        assign clr_vec[gi]  = alloc_hit;
        assign ent_wd[gi]   = wd;
        assign wr_we[gi]    = run && hit && (gi != 0);
        assign sweep_we[gi] = !run && (CNT_W'(gi) >= cnt_reg)
                              && ((CNT_W+1)'(gi) < cnt_plus);
    end

    // Control FSM: reset restarts the zeroing sweep; RUN is held until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            cnt_reg       <= CNT_W'(1);
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    cnt_reg <= cnt_plus[CNT_W-1:0];
                    if (init_last) begin
                        state_reg     <= ST_RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    // Data storage: entry 0 is constant zero; others take the sweep or a writeback.
    always_ff @(posedge clk) begin
        mem[0] <= '0;
        if (!rst) begin
            for (int e = 1; e < PRF_NUMS; e++) begin
                if (sweep_we[e]) begin
                    mem[e] <= '0;
                end else if (wr_we[e]) begin
                    mem[e] <= ent_wd[e];
                end
            end
        end
    end

    // Scoreboard update: clear beats set so a fresh allocation wins over a stale writeback.
    always_comb begin
        ready_next = ready_reg;
        if (run) begin
            ready_next = (ready_reg | set_vec) & ~clr_vec;
        end
        ready_next[0] = 1'b1;
    end

    // Scoreboard register; all entries report ready out of reset and during the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_reg <= '1;
        end else begin
            ready_reg <= ready_next;
        end
    end

    // Read ports: stored value, optionally overridden by a same-cycle write.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [CODE_W-1:0] rc;
        logic [DATA_W-1:0] rd;

        assign rc = i_rd_code[gi*CODE_W +: CODE_W];

        // Code 0 and every read during the sweep return zero.
        always_comb begin
            rd = mem[rc];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (i_wr_en[p] && (i_wr_code[p*CODE_W +: CODE_W] == rc)) begin
                        rd = i_wr_data[p*DATA_W +: DATA_W];
                    end
                end
            end
            if ((rc == '0) || !run) begin
                rd = '0;
            end
        end

        assign o_rd_data[gi*DATA_W +: DATA_W] = rd;
    end

    assign o_ready     = ready_reg;
    assign o_init_done = init_done_reg;

endmodule

// File: tb/tb_rsv_prf_param.sv
// Bench for rsv_prf_param: a default instance (BYPASS=1) and a reduced instance
// (32 entries, 2 write / 3 read / 1 alloc ports, BYPASS=0) share one clock.
// A per-cycle model comparison runs alongside directed checks that use literal expectations.
module tb_rsv_prf_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults.
    logic          rst_a;
    logic [3:0]    a_alloc_vld;
    logic [27:0]   a_alloc_code;
    logic [55:0]   a_rd_code;
    logic [511:0]  a_rd_data;
    logic [3:0]    a_wr_en;
    logic [27:0]   a_wr_code;
    logic [255:0]  a_wr_data;
    logic [127:0]  a_ready;
    logic          a_done;

    // Instance 1: reduced configuration.
    logic          rst_b;
    logic [0:0]    b_alloc_vld;
    logic [4:0]    b_alloc_code;
    logic [14:0]   b_rd_code;
    logic [191:0]  b_rd_data;
    logic [1:0]    b_wr_en;
    logic [9:0]    b_wr_code;
    logic [127:0]  b_wr_data;
    logic [31:0]   b_ready;
    logic          b_done;

    rsv_prf_param dut_a (
        .clk(clk), .rst(rst_a),
        .i_alloc_vld(a_alloc_vld), .i_alloc_code(a_alloc_code),
        .i_rd_code(a_rd_code), .o_rd_data(a_rd_data),
        .i_wr_en(a_wr_en), .i_wr_code(a_wr_code), .i_wr_data(a_wr_data),
        .o_ready(a_ready), .o_init_done(a_done)
    );

    rsv_prf_param #(
        .PRF_NUMS(32), .DATA_W(64), .NUM_RD(3), .NUM_WR(2), .NUM_ALLOC(1), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst_b),
        .i_alloc_vld(b_alloc_vld), .i_alloc_code(b_alloc_code),
        .i_rd_code(b_rd_code), .o_rd_data(b_rd_data),
        .i_wr_en(b_wr_en), .i_wr_code(b_wr_code), .i_wr_data(b_wr_data),
        .o_ready(b_ready), .o_init_done(b_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Configuration per instance.
    function automatic int np(input int k);  return (k == 0) ? 128 : 32; endfunction
    function automatic int nwr(input int k); return (k == 0) ? 4 : 2;    endfunction
    function automatic int nal(input int k); return (k == 0) ? 4 : 1;    endfunction
    function automatic int nrd(input int k); return (k == 0) ? 8 : 3;    endfunction
    function automatic bit byp(input int k); return (k == 0);            endfunction

    function automatic logic [127:0] ones(input int k);
        logic [127:0] m;
        m = (k == 0) ? {128{1'b1}} : {96'd0, 32'hFFFF_FFFF};
        return m;
    endfunction

    // Port accessors.
    function automatic bit f_rst(input int k); return (k == 0) ? rst_a : rst_b; endfunction
    function automatic bit f_wen(input int k, input int p);
        return (k == 0) ? a_wr_en[p] : b_wr_en[p];
    endfunction
    function automatic int f_wcode(input int k, input int p);
        return (k == 0) ? int'(a_wr_code[p*7 +: 7]) : int'(b_wr_code[p*5 +: 5]);
    endfunction
    function automatic logic [63:0] f_wdata(input int k, input int p);
        return (k == 0) ? a_wr_data[p*64 +: 64] : b_wr_data[p*64 +: 64];
    endfunction
    function automatic bit f_aen(input int k, input int a);
        return (k == 0) ? a_alloc_vld[a] : b_alloc_vld[a];
    endfunction
    function automatic int f_acode(input int k, input int a);
        return (k == 0) ? int'(a_alloc_code[a*7 +: 7]) : int'(b_alloc_code[a*5 +: 5]);
    endfunction
    function automatic int f_rcode(input int k, input int r);
        return (k == 0) ? int'(a_rd_code[r*7 +: 7]) : int'(b_rd_code[r*5 +: 5]);
    endfunction
    function automatic logic [63:0] f_rd(input int k, input int r);
        return (k == 0) ? a_rd_data[r*64 +: 64] : b_rd_data[r*64 +: 64];
    endfunction
    function automatic logic [127:0] f_ready(input int k);
        return (k == 0) ? a_ready : {96'd0, b_ready};
    endfunction
    function automatic bit f_done(input int k); return (k == 0) ? a_done : b_done; endfunction

    // Drivers.
    task automatic set_rst(input int k, input bit v);
        if (k == 0) rst_a = v; else rst_b = v;
    endtask
    task automatic set_wr(input int k, input int p, input bit en, input int code, input logic [63:0] d);
        if (k == 0) begin
            a_wr_en[p] = en; a_wr_code[p*7 +: 7] = code[6:0]; a_wr_data[p*64 +: 64] = d;
        end else begin
            b_wr_en[p] = en; b_wr_code[p*5 +: 5] = code[4:0]; b_wr_data[p*64 +: 64] = d;
        end
    endtask
    task automatic set_al(input int k, input int a, input bit en, input int code);
        if (k == 0) begin
            a_alloc_vld[a] = en; a_alloc_code[a*7 +: 7] = code[6:0];
        end else begin
            b_alloc_vld[a] = en; b_alloc_code[a*5 +: 5] = code[4:0];
        end
    endtask
    task automatic set_rd(input int k, input int r, input int code);
        if (k == 0) a_rd_code[r*7 +: 7] = code[6:0];
        else        b_rd_code[r*5 +: 5] = code[4:0];
    endtask
    task automatic idle(input int k);
        if (k == 0) begin a_wr_en = '0; a_alloc_vld = '0; end
        else        begin b_wr_en = '0; b_alloc_vld = '0; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // INIT is modelled as a plain countdown of ceil((P-1)/W) cycles after which
    // every entry holds zero; RUN applies the architectural write/alloc rules.
    logic [63:0]  m_data  [2][128];
    logic [127:0] m_ready [2];
    int           m_left  [2];
    bit           m_done  [2];
    bit           m_valid [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_done[k] = 1'b0; m_left[k] = 0; m_ready[k] = '0;
        end
    end

    task automatic model_step(input int k);
        logic [127:0] setv;
        logic [127:0] clrv;
        if (f_rst(k)) begin
            m_valid[k] = 1'b1;
            m_left[k]  = (np(k) - 1 + nwr(k) - 1) / nwr(k);
            m_done[k]  = 1'b0;
            m_ready[k] = ones(k);
        end else if (m_valid[k]) begin
            if (m_left[k] > 0) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_done[k] = 1'b1;
                    for (int e = 0; e < np(k); e++) m_data[k][e] = '0;
                end
            end else begin
                setv = '0;
                clrv = '0;
                for (int p = 0; p < nwr(k); p++) begin
                    if (f_wen(k, p)) begin
                        setv[f_wcode(k, p)] = 1'b1;
                        if (f_wcode(k, p) != 0) m_data[k][f_wcode(k, p)] = f_wdata(k, p);
                    end
                end
                for (int a = 0; a < nal(k); a++) begin
                    if (f_aen(k, a)) clrv[f_acode(k, a)] = 1'b1;
                end
                m_ready[k] = (m_ready[k] | setv) & ~clrv;
                m_ready[k][0] = 1'b1;
            end
        end
    endtask

    function automatic logic [63:0] exp_rd(input int k, input int code);
        logic [63:0] v;
        if (code == 0 || m_left[k] > 0) return 64'd0;
        v = m_data[k][code];
        if (byp(k)) begin
            for (int p = 0; p < nwr(k); p++) begin
                if (f_wen(k, p) && f_wcode(k, p) == code) v = f_wdata(k, p);
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_valid[k]) begin
                chk($sformatf("mdl%0d_done", k), {127'd0, f_done(k)}, {127'd0, m_done[k]});
                chk($sformatf("mdl%0d_ready", k), f_ready(k), m_ready[k]);
                for (int r = 0; r < nrd(k); r++) begin
                    chk($sformatf("mdl%0d_rd%0d", k, r), {64'd0, f_rd(k, r)},
                        {64'd0, exp_rd(k, f_rcode(k, r))});
                end
            end
        end
    end

    // ---------------- directed scenario ----------------
    task automatic run_scen(input int k);
        int nc;
        int wa;
        int wb;
        int exp_cyc;
        logic [127:0] rdy;
        wa      = (k == 0) ? 1 : 0;
        wb      = (k == 0) ? 3 : 1;
        exp_cyc = (k == 0) ? 33 : 17;

        set_rst(k, 1'b1);
        tick();
        tick();
        set_rst(k, 1'b0);
        nc = 1;
        while (!f_done(k) && nc < 200) begin
            tick();
            nc++;
        end
        chk($sformatf("dir%0d_init_cycle", k), 128'(nc), 128'(exp_cyc));

        set_rd(k, 0, 1);
        set_rd(k, 1, np(k) / 2);
        set_rd(k, 2, np(k) - 1);
        #1;
        chk($sformatf("dir%0d_rd_first", k), {64'd0, f_rd(k, 0)}, 128'd0);
        chk($sformatf("dir%0d_rd_mid", k),   {64'd0, f_rd(k, 1)}, 128'd0);
        chk($sformatf("dir%0d_rd_last", k),  {64'd0, f_rd(k, 2)}, 128'd0);
        chk($sformatf("dir%0d_ready_ones", k), f_ready(k), ones(k));

        // Allocate 5 -> not ready.
        set_al(k, 0, 1'b1, 5);
        tick();
        idle(k);
        rdy = f_ready(k);
        chk($sformatf("dir%0d_alloc5", k), 128'(rdy[5]), 128'd0);

        // Write 5 with a same-cycle read.
        set_wr(k, 0, 1'b1, 5, 64'hDEAD_BEEF);
        set_rd(k, 0, 5);
        #1;
        chk($sformatf("dir%0d_byp5", k), {64'd0, f_rd(k, 0)},
            byp(k) ? 128'hDEAD_BEEF : 128'd0);
        tick();
        idle(k);
        rdy = f_ready(k);
        chk($sformatf("dir%0d_ready5", k), 128'(rdy[5]), 128'd1);
        chk($sformatf("dir%0d_rd5", k), {64'd0, f_rd(k, 0)}, 128'hDEAD_BEEF);

        // Two ports write 9: higher port wins.
        set_wr(k, wa, 1'b1, 9, 64'h11);
        set_wr(k, wb, 1'b1, 9, 64'h33);
        set_rd(k, 1, 9);
        #1;
        chk($sformatf("dir%0d_byp9", k), {64'd0, f_rd(k, 1)}, byp(k) ? 128'h33 : 128'd0);
        tick();
        idle(k);
        chk($sformatf("dir%0d_rd9", k), {64'd0, f_rd(k, 1)}, 128'h33);

        // Write and alloc 12 together: clear wins, data kept.
        set_wr(k, 0, 1'b1, 12, 64'h1234);
        set_al(k, 0, 1'b1, 12);
        set_rd(k, 2, 12);
        tick();
        idle(k);
        rdy = f_ready(k);
        chk($sformatf("dir%0d_ready12", k), 128'(rdy[12]), 128'd0);
        chk($sformatf("dir%0d_rd12", k), {64'd0, f_rd(k, 2)}, 128'h1234);

        // Code 0 stays zero and ready.
        set_wr(k, wb, 1'b1, 0, 64'hFF);
        set_al(k, 0, 1'b1, 0);
        set_rd(k, 0, 0);
        #1;
        chk($sformatf("dir%0d_byp0", k), {64'd0, f_rd(k, 0)}, 128'd0);
        tick();
        idle(k);
        rdy = f_ready(k);
        chk($sformatf("dir%0d_rd0", k), {64'd0, f_rd(k, 0)}, 128'd0);
        chk($sformatf("dir%0d_ready0", k), 128'(rdy[0]), 128'd1);

        // Fill 7, then reset and try to write 7 during INIT.
        set_wr(k, 0, 1'b1, 7, 64'h77);
        tick();
        idle(k);
        set_rd(k, 1, 7);
        #1;
        chk($sformatf("dir%0d_rd7", k), {64'd0, f_rd(k, 1)}, 128'h77);
        set_rst(k, 1'b1);
        tick();
        set_rst(k, 1'b0);
        chk($sformatf("dir%0d_rst_done", k), {127'd0, f_done(k)}, 128'd0);
        chk($sformatf("dir%0d_rst_ready", k), f_ready(k), ones(k));
        set_wr(k, 0, 1'b1, 7, 64'hAA);
        tick();
        idle(k);
        nc = 0;
        while (!f_done(k) && nc < 200) begin
            tick();
            nc++;
        end
        chk($sformatf("dir%0d_reinit_done", k), {127'd0, f_done(k)}, 128'd1);
        #1;
        chk($sformatf("dir%0d_rd7_cleared", k), {64'd0, f_rd(k, 1)}, 128'd0);
        tick();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_alloc_vld = '0; a_alloc_code = '0; a_rd_code = '0;
        a_wr_en = '0; a_wr_code = '0; a_wr_data = '0;
        b_alloc_vld = '0; b_alloc_code = '0; b_rd_code = '0;
        b_wr_en = '0; b_wr_code = '0; b_wr_data = '0;
        tick();
        run_scen(0);
        run_scen(1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
